apple_spawner: RTL
==================

# apple_spawner

Generates the next apple position for the snake game on the 160x120 VGA grid of 10x10 cells. It sits upstream of the game's draw/erase FSM, which only reads the apple coordinates and redraws them. On a spawn request it draws pseudo-random cell candidates from a free-running LFSR. It rejects any candidate outside the screen or under a snake segment, then presents a registered, cell-aligned apple position with a one-cycle valid pulse.

## Interface
Parameters:
- XDIM, 10: cell width in pixels.
- YDIM, 10: cell height in pixels.
- MAXLEN, 4: maximum snake segments.
- SEED, 16'h0001: LFSR reset value. A value of 0 is replaced by 16'h0001.
- MAX_TRIES, 64: rejected candidates before giving up. Legal range 1..255.
- APPLE_X0, 8'd30: apple X reset value.
- APPLE_Y0, 7'd30: apple Y reset value.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- req  in  1  spawn request. Sampled only in IDLE.
- body_x  in  8*MAXLEN  segment i X at [8*i +: 8]; segment 0 is the head.
- body_y  in  7*MAXLEN  segment i Y at [7*i +: 7].
- length  in  4  valid segment count. Values above MAXLEN are clamped to MAXLEN.
- apple_x  out  8  current apple X, registered.
- apple_y  out  7  current apple Y, registered.
- valid  out  1  one-cycle pulse: new apple presented.
- fail  out  1  one-cycle pulse: MAX_TRIES exhausted, apple unchanged.
- busy  out  1  high whenever state != IDLE.

## Operation
- LFSR: 16-bit Fibonacci.
  - Next value = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Advances every cycle in every state. Loaded with SEED during reset.
- Candidate: col = lfsr[3:0] (0..15), row = lfsr[7:4].
  - cand_x = col*XDIM, cand_y = row*YDIM, computed with shift-add in 8 and 7 bits.
  - Rows 12..15 are rejected.
- On accepting a req, body_x, body_y and clamped length are latched. Later input changes are ignored until IDLE.
- States:
  - IDLE: req=1 → PICK. Clear tries.
  - PICK: if row>=12, tries+1 and stay in PICK (or go to FAIL if tries reaches MAX_TRIES). Otherwise latch candidate, idx=0, then go to CHECK, or directly to DONE if latched length==0.
  - CHECK: compare latched segment idx with the candidate, one segment per cycle, exact equality on both X and Y.
    - Match: tries+1, then go to FAIL if tries==MAX_TRIES, else PICK.
    - No match and idx==length-1: go to DONE.
    - Otherwise: idx+1.
  - DONE: valid=1. Next state IDLE.
  - FAIL: fail=1. Next state IDLE.
- apple_x and apple_y load the candidate on the edge entering DONE and hold otherwise.
- req outside IDLE is ignored. A req held high re-triggers on the cycle after DONE/FAIL.

## Timing
- Reset values:
  - state=IDLE.
  - apple_x=APPLE_X0, apple_y=APPLE_Y0.
  - valid=0, fail=0, busy=0, lfsr=SEED.
- Reset asserted in any state returns to IDLE next cycle with reset values. No valid or fail pulse is produced.
- Latency for a req sampled at cycle t with no rejections: PICK at t+1, CHECK at t+2..t+1+L, DONE at t+2+L.
  - With length 0, DONE is at t+2.
- Each rejection adds 1 cycle for a row reject, or 1 + (segments compared) cycles for a body collision.
- valid and fail are registered state decodes and never both high.
- busy is decoded from state.
- New apple_x/apple_y are visible in the same cycle valid is high.

## Test plan
- Reset, then idle 5 cycles → apple=(30,30), valid=0, fail=0, busy=0 throughout.
- SEED=1, length=0, req at cycle 0 (first cycle after reset) → PICK sees lfsr=0x0002; valid at cycle 2 with apple=(20,0); busy high at cycles 1-2.
- SEED=1, length=1, segment0=(20,0), req at cycle 0 → collision at cycle 2, re-PICK at cycle 3 with lfsr=0x0008; valid at cycle 5 with apple=(80,0).
- MAX_TRIES=2, length=2, seg0=(20,0), seg1=(80,0), req at cycle 0 → fail pulse at cycle 6, valid never asserted, apple stays (30,30).
- Random seeds, random bodies of length 1..MAXLEN, 1000 requests checked against a C model of the LFSR → every valid apple has X%10==0, X<=150, Y%10==0, Y<=110, and no overlap with the latched body. Cycle counts match the model.
- Reset asserted mid-CHECK, and req pulses while busy → IDLE next cycle after reset with lfsr=SEED; requests during busy produce no extra valid.

Source files
------------

// File: rtl/apple_spawner_if.sv
// Spawn request/response bundle between the game controller and apple_spawner.
// Body coordinates are flat vectors: segment i X at [8*i +: 8], Y at [7*i +: 7].
interface apple_spawner_if #(
    parameter int MAXLEN = 4
);
    logic                  req;
    logic [8*MAXLEN-1:0]   body_x;
    logic [7*MAXLEN-1:0]   body_y;
    logic [3:0]            length;
    logic [7:0]            apple_x;
    logic [6:0]            apple_y;
    logic                  valid;
    logic                  fail;
    logic                  busy;

    modport master (
        output req, body_x, body_y, length,
        input  apple_x, apple_y, valid, fail, busy
    );

    modport slave (
        input  req, body_x, body_y, length,
        output apple_x, apple_y, valid, fail, busy
    );
endinterface

// File: rtl/apple_spawner.sv
// Picks a random free grid cell for the next apple: LFSR candidate, off-screen
// rows rejected, body collisions checked one segment per cycle.
module apple_spawner #(
    parameter int          XDIM      = 10,
    parameter int          YDIM      = 10,
    parameter int          MAXLEN    = 4,
    parameter logic [15:0] SEED      = 16'h0001,
    parameter int          MAX_TRIES = 64,
    parameter logic [7:0]  APPLE_X0  = 8'd30,
    parameter logic [6:0]  APPLE_Y0  = 7'd30
) (
    input  logic           clk,
    input  logic           reset,
    apple_spawner_if.slave bus
);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  TRY_LIM  = 8'(MAX_TRIES);
    localparam logic [3:0]  ROWS     = 4'(120 / YDIM);
    localparam logic [3:0]  LEN_MAX  = 4'(MAXLEN);
    localparam int          IW       = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

    typedef enum logic [2:0] {IDLE, PICK, CHECK, DONE, FAIL} state_t;

    state_t                  state_q, state_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [7:0]              tries_q, tries_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              cand_x_q, cand_x_d;
    logic [6:0]              cand_y_q, cand_y_d;
    logic [MAXLEN-1:0][7:0]  bx_q, bx_d;
    logic [MAXLEN-1:0][6:0]  by_q, by_d;
    logic [3:0]              len_q, len_d;
    logic [7:0]              apple_x_q, apple_x_d;
    logic [6:0]              apple_y_q, apple_y_d;

    logic [3:0] col, row;
    logic [7:0] new_x, tries_inc;
    logic [6:0] new_y;
    logic       row_bad, at_lim, hit, last;

    always_comb begin
        col       = lfsr_q[3:0];
        row       = lfsr_q[7:4];
        // Constant multiplies reduce to shift-add (col*8 + col*2 for 10).
        new_x     = 8'(col * XDIM);
        new_y     = 7'(row * YDIM);
        row_bad   = (row >= ROWS);
        tries_inc = tries_q + 8'd1;
        at_lim    = (tries_inc == TRY_LIM);
        hit       = (bx_q[idx_q] == cand_x_q) && (by_q[idx_q] == cand_y_q);
        last      = (4'(idx_q) == (len_q - 4'd1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED_EFF;
            tries_q   <= '0;
            idx_q     <= '0;
            cand_x_q  <= '0;
            cand_y_q  <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            len_q     <= '0;
            apple_x_q <= APPLE_X0;
            apple_y_q <= APPLE_Y0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            tries_q   <= tries_d;
            idx_q     <= idx_d;
            cand_x_q  <= cand_x_d;
            cand_y_q  <= cand_y_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            len_q     <= len_d;
            apple_x_q <= apple_x_d;
            apple_y_q <= apple_y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.req) state_d = PICK;
            PICK: begin
                if (row_bad) begin
                    if (at_lim) state_d = FAIL;
                end else begin
                    state_d = (len_q == 4'd0) ? DONE : CHECK;
                end
            end
            CHECK: begin
                if (hit)       state_d = at_lim ? FAIL : PICK;
                else if (last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        tries_d   = tries_q;
        idx_d     = idx_q;
        cand_x_d  = cand_x_q;
        cand_y_d  = cand_y_q;
        bx_d      = bx_q;
        by_d      = by_q;
        len_d     = len_q;
        apple_x_d = apple_x_q;
        apple_y_d = apple_y_q;
        case (state_q)
            IDLE: begin
                tries_d = '0;
                // Snapshot the body so a moving snake cannot disturb the check.
                if (bus.req) begin
                    bx_d  = bus.body_x;
                    by_d  = bus.body_y;
                    len_d = (bus.length > LEN_MAX) ? LEN_MAX : bus.length;
                end
            end
            PICK: begin
                if (row_bad) begin
                    tries_d = tries_inc;
                end else begin
                    cand_x_d = new_x;
                    cand_y_d = new_y;
                    idx_d    = '0;
                end
            end
            CHECK: begin
                if (hit)        tries_d = tries_inc;
                else if (!last) idx_d   = idx_q + IW'(1);
            end
            default: ;
        endcase
        if (state_d == DONE) begin
            apple_x_d = cand_x_d;
            apple_y_d = cand_y_d;
        end
    end

    always_comb begin
        bus.apple_x = apple_x_q;
        bus.apple_y = apple_y_q;
        bus.valid   = (state_q == DONE);
        bus.fail    = (state_q == FAIL);
        bus.busy    = (state_q != IDLE);
    end
endmodule
